// File: rtl/pattern_scan_ctrl.sv
// Frame sequencer for the serial 101/010 Mealy detector: shifts a parallel frame
// out MSB first, samples the detector output each bit, and tallies per-pattern hits.
module pattern_scan_ctrl #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] frame,
    output logic             busy,
    output logic             done,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic [1:0]       det_o,
    output logic [CNT_W-1:0] cnt101,
    output logic [CNT_W-1:0] cnt010
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] MASK_IDX = IDX_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [IDX_W-1:0] idx_r;
    logic             hit_en_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic hit);
        if (hit && (val != CNT_MAX)) begin
            return val + CNT_ONE;
        end else begin
            return val;
        end
    endfunction

    // The first two bits' windows reach back into idle-line or previous-frame history.
    always_comb begin
        hit_en_s = 1'b0;
        if (idx_r >= MASK_IDX) begin
            hit_en_s = 1'b1;
        end else begin
            hit_en_s = 1'b0;
        end
    end

    // Sequencer state, shift register, hit counters and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            shreg_r   <= {WIDTH{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            cnt101    <= {CNT_W{1'b0}};
            cnt010    <= {CNT_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        state_r   <= SHIFT;
                        shreg_r   <= frame;
                        idx_r     <= {IDX_W{1'b0}};
                        cnt101    <= {CNT_W{1'b0}};
                        cnt010    <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
                        ser_bit   <= frame[WIDTH-1];
                        ser_valid <= 1'b1;
                    end else begin
                        busy      <= 1'b0;
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_r   <= IDLE;
                        idx_r     <= {IDX_W{1'b0}};
                        cnt101    <= {CNT_W{1'b0}};
                        cnt010    <= {CNT_W{1'b0}};
                        busy      <= 1'b0;
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                    end else begin
                        shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                        cnt101  <= sat_inc(cnt101, hit_en_s & det_o[1]);
                        cnt010  <= sat_inc(cnt010, hit_en_s & det_o[0]);
                        if (idx_r == LAST_IDX) begin
                            state_r   <= DONE;
                            idx_r     <= {IDX_W{1'b0}};
                            done      <= 1'b1;
                            ser_bit   <= 1'b0;
                            ser_valid <= 1'b0;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            ser_bit <= shreg_r[WIDTH-2];
                        end
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    ser_bit   <= 1'b0;
                    ser_valid <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    ser_bit   <= 1'b0;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: two instances (CNT_W 4 and 2), each driving
// its own reset-gated 101/010 Mealy detector model.
module tb_pattern_scan_ctrl;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [8:0] frame;

    logic       busy, done, ser_bit, ser_valid;
    logic [1:0] det_o;
    logic [3:0] cnt101, cnt010;

    logic       busy_s, done_s, ser_bit_s, ser_valid_s;
    logic [1:0] det_o_s;
    logic [1:0] cnt101_s, cnt010_s;

    logic [1:0] hist_r, hist_s_r;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] c101;
        logic [3:0] c010;
        logic [1:0] s101;
        logic [1:0] s010;
    } exp_t;

    exp_t sb[$];

    pattern_scan_ctrl #(.WIDTH(9), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .frame(frame),
        .busy(busy), .done(done), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .det_o(det_o), .cnt101(cnt101), .cnt010(cnt010)
    );

    pattern_scan_ctrl #(.WIDTH(9), .CNT_W(2)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .frame(frame),
        .busy(busy_s), .done(done_s), .ser_bit(ser_bit_s), .ser_valid(ser_valid_s),
        .det_o(det_o_s), .cnt101(cnt101_s), .cnt010(cnt010_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Detector models: history of the last two serial bits, Mealy output on the current bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_r   <= 2'b00;
            hist_s_r <= 2'b00;
        end else begin
            hist_r   <= {hist_r[0], ser_bit};
            hist_s_r <= {hist_s_r[0], ser_bit_s};
        end
    end

    assign det_o   = {(hist_r == 2'b10) && ser_bit,     (hist_r == 2'b01) && !ser_bit};
    assign det_o_s = {(hist_s_r == 2'b10) && ser_bit_s, (hist_s_r == 2'b01) && !ser_bit_s};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input int e101, input int e010);
        exp_t e;
        e.c101 = 4'(e101);
        e.c010 = 4'(e010);
        e.s101 = (e101 > 3) ? 2'd3 : 2'(e101);
        e.s010 = (e010 > 3) ? 2'd3 : 2'(e010);
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            check("sat_inst_sync", {28'd0, busy_s, done_s, ser_valid_s, ser_bit_s},
                  {28'd0, busy, done, ser_valid, ser_bit});
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("cnt101",   {28'd0, cnt101},   {28'd0, e.c101});
                    check("cnt010",   {28'd0, cnt010},   {28'd0, e.c010});
                    check("cnt101_s", {30'd0, cnt101_s}, {30'd0, e.s101});
                    check("cnt010_s", {30'd0, cnt010_s}, {30'd0, e.s010});
                end
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after done.
    task automatic run_frame(input logic [8:0] f, input int e101, input int e010, input bit hold);
        sb.push_back(make_exp(e101, e010));
        start = 1'b1;
        frame = f;
        @(negedge clock);
        if (!hold) start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("busy_shift",  {31'd0, busy},      32'd1);
            check("valid_shift", {31'd0, ser_valid}, 32'd1);
            check("ser_bit",     {31'd0, ser_bit},   {31'd0, f[8-k]});
            check("done_early",  {31'd0, done},      32'd0);
            @(negedge clock);
        end
        start = 1'b0;
        check("done_pulse",  {31'd0, done},      32'd1);
        check("busy_done",   {31'd0, busy},      32'd1);
        check("valid_done",  {31'd0, ser_valid}, 32'd0);
        @(negedge clock);
        check("busy_idle",   {31'd0, busy},      32'd0);
        check("done_single", {31'd0, done},      32'd0);
    endtask

    task automatic check_quiet(input string name);
        check(name, {24'd0, busy, done, ser_bit, ser_valid, cnt101}, 32'd0);
        check({name, "_c010"}, {28'd0, cnt010}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        frame   = 9'd0;
        @(negedge clock);
        check_quiet("reset_state");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_quiet("after_reset");

        // Basic frame, then alternating pattern that saturates the 2-bit counters.
        run_frame(9'b101001101, 2, 1, 1'b0);
        run_frame(9'b010101010, 3, 4, 1'b0);

        // Back-to-back frames; the second one holds start high during SHIFT.
        run_frame(9'b000000101, 1, 1, 1'b0);
        run_frame(9'b000000000, 0, 0, 1'b1);
        @(negedge clock);
        check("start_not_queued", {31'd0, busy}, 32'd0);

        // Abort at idx 4 clears everything and suppresses done.
        start = 1'b1;
        frame = 9'b101001101;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_quiet("abort");
        repeat (12) begin
            @(negedge clock);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_frame(9'b101001101, 2, 1, 1'b0);

        // Asynchronous reset mid-frame.
        start = 1'b1;
        frame = 9'b101001101;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_quiet("async_reset");
        #5 reset_n = 1'b1;
        @(negedge clock);
        check_quiet("post_reset");
        run_frame(9'b010101010, 3, 4, 1'b0);

        // start together with abort in IDLE is refused.
        start = 1'b1;
        abort = 1'b1;
        frame = 9'b111111111;
        @(negedge clock);
        check("start_abort_busy",  {31'd0, busy},      32'd0);
        check("start_abort_valid", {31'd0, ser_valid}, 32'd0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        check("start_abort_idle",  {31'd0, busy},      32'd0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
